// File: rtl/calc_pkg.sv
// Types shared by the op sequencer and the calculator chip: opcode encoding,
// sequencer FSM states and the debug view exported by the sequencer.
package calc_pkg;

   typedef enum logic [1:0] {
      CALC_ADD      = 2'b00,
      CALC_SUBTRACT = 2'b01,
      CALC_OR       = 2'b10,
      CALC_EQUALS   = 2'b11
   } calc_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } seq_state_t;

   localparam int CMD_W = 10;

   // count is wide enough for the largest supported FIFO (16 entries)
   typedef struct packed {
      seq_state_t  state;
      logic [4:0]  count;
   } seq_dbg_t;

   function automatic logic [CMD_W-1:0] pack_cmd(calc_op_t op, logic [7:0] num);
      return {op, num};
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO holding {op,num} entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module cmd_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [CMD_W-1:0]         wdata,
   output logic [CMD_W-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/calc_op_sequencer.sv
// Queues calculator commands and plays them one at a time into the calculator,
// returning each NumOut sample as a response.
// Handshakes: a transfer happens on a posedge where valid && ready; the
// producer holds data stable while valid && !ready.
module calc_op_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int RESULT_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  calc_op_t   cmd_op,
   input  logic [7:0] cmd_num,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] calc_num,
   output calc_op_t   calc_op,
   output logic       calc_enter,
   input  logic [7:0] calc_result,
   output logic       busy,
   output seq_dbg_t   dbg
);

   localparam logic [3:0] LAST_WAIT = 4'(RESULT_LAT - 1);

   seq_state_t              state;
   seq_state_t              state_next;
   logic [3:0]              wait_cnt;
   logic [3:0]              wait_next;
   logic                    load_cmd;
   logic                    pop;
   logic                    capture;
   logic                    push;
   logic [CMD_W-1:0]        head;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    full;
   logic                    empty;

   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (pack_cmd(cmd_op, cmd_num)),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   // The head is latched on the IDLE->ISSUE edge so the calculator inputs are
   // already valid during the ISSUE cycle that pops the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         calc_num   <= '0;
         calc_op    <= CALC_ADD;
         calc_enter <= 1'b0;
         rsp_data   <= '0;
      end else begin
         state      <= state_next;
         wait_cnt   <= wait_next;
         calc_enter <= load_cmd;
         if (load_cmd) begin
            calc_op  <= calc_op_t'(head[9:8]);
            calc_num <= head[7:0];
         end
         if (capture) rsp_data <= calc_result;
      end
   end

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      load_cmd   = 1'b0;
      pop        = 1'b0;
      capture    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               load_cmd   = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pop        = 1'b1;
            wait_next  = '0;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
               capture    = 1'b1;
               state_next = S_RESP;
            end else begin
               wait_next = wait_cnt + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE) || !empty;
   assign dbg.state = state;
   assign dbg.count = 5'(fifo_count);

endmodule
